// File: rtl/result_pkg.sv
// Shared encodings for the dice/lights result bus checker.
package result_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_e;

    localparam logic [2:0] LIGHT_RED = 3'b100;
    localparam logic [2:0] LIGHT_RA  = 3'b110;
    localparam logic [2:0] LIGHT_GRN = 3'b001;
    localparam logic [2:0] LIGHT_AMB = 3'b010;

    localparam logic [2:0] DICE_MIN  = 3'd1;
    localparam logic [2:0] DICE_MAX  = 3'd6;

endpackage

// File: rtl/result_predict.sv
// Combinational predictor: next legal value from the previous sample, plus
// legality of the value currently on the bus for the selected source.
module result_predict
    import result_pkg::*;
(
    input  logic       sel,
    input  logic [2:0] last_val,
    input  logic       btn_q,
    input  logic [2:0] result,
    output logic [2:0] expected,
    output logic       legal
);

    always_comb begin
        expected = last_val;
        if (sel) begin
            case (last_val)
                LIGHT_RED: expected = LIGHT_RA;
                LIGHT_RA:  expected = LIGHT_GRN;
                LIGHT_GRN: expected = LIGHT_AMB;
                LIGHT_AMB: expected = LIGHT_RED;
                default:   expected = LIGHT_RED;
            endcase
        end else if (btn_q) begin
            expected = (last_val == DICE_MAX) ? DICE_MIN : last_val + 3'd1;
        end
    end

    always_comb begin
        if (sel)
            legal = (result == LIGHT_RED) || (result == LIGHT_RA) ||
                    (result == LIGHT_GRN) || (result == LIGHT_AMB);
        else
            legal = (result >= DICE_MIN) && (result <= DICE_MAX);
    end

endmodule

// File: rtl/result_checker.sv
// Live protocol monitor for the muxed result bus: locks onto the dice or
// lights sequence and pulses err on any deviation once locked.
module result_checker
    import result_pkg::*;
#(
    parameter int LOCK_LEN = 3,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sel,
    input  logic             button,
    input  logic [2:0]       result,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_count,
    output logic [2:0]       last_val
);

    localparam logic [3:0] LOCK_CNT = 4'(LOCK_LEN);

    state_e     state, state_nx;
    logic [3:0] match_cnt, cnt_nx;
    logic       btn_q, sel_q, primed;
    logic       err_nx, legal;
    logic [2:0] expected;

    result_predict u_predict (
        .sel      (sel),
        .last_val (last_val),
        .btn_q    (btn_q),
        .result   (result),
        .expected (expected),
        .legal    (legal)
    );

    // sel_q holds no meaningful source until the first edge after reset,
    // so the source-change rule is gated until then.
    always_comb begin
        state_nx = state;
        cnt_nx   = match_cnt;
        err_nx   = 1'b0;
        if (primed && (sel != sel_q)) begin
            state_nx = HUNT;
            cnt_nx   = 4'd0;
        end else begin
            case (state)
                HUNT: begin
                    if (legal) begin
                        state_nx = VERIFY;
                        cnt_nx   = 4'd0;
                    end
                end
                VERIFY: begin
                    if (result == expected) begin
                        cnt_nx = match_cnt + 4'd1;
                        if (cnt_nx == LOCK_CNT) state_nx = LOCKED;
                    end else begin
                        cnt_nx   = 4'd0;
                        state_nx = legal ? VERIFY : HUNT;
                    end
                end
                LOCKED: begin
                    if (result != expected) begin
                        err_nx   = 1'b1;
                        cnt_nx   = 4'd0;
                        state_nx = legal ? VERIFY : HUNT;
                    end
                end
                default: begin
                    state_nx = HUNT;
                    cnt_nx   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= HUNT;
            match_cnt <= 4'd0;
            err       <= 1'b0;
            err_count <= '0;
            last_val  <= 3'd0;
            btn_q     <= 1'b0;
            sel_q     <= 1'b0;
            primed    <= 1'b0;
        end else begin
            state     <= state_nx;
            match_cnt <= cnt_nx;
            err       <= err_nx;
            if (err_nx && (err_count != '1)) err_count <= err_count + 1'b1;
            last_val  <= result;
            btn_q     <= button;
            sel_q     <= sel;
            primed    <= 1'b1;
        end
    end

    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_result_checker.sv
// Directed bench for result_checker: vector table for the dice/lights
// protocol walk, hand sequences for counter saturation and async reset.
module tb_result_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sel = 1'b0;
    logic       button = 1'b0;
    logic [2:0] result = 3'd0;

    logic       locked8, err8, locked2, err2;
    logic [7:0] cnt8;
    logic [1:0] cnt2;
    logic [2:0] last8, last2;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    result_checker #(.LOCK_LEN(3), .ERR_W(8)) u8 (
        .clk(clk), .rst(rst), .sel(sel), .button(button), .result(result),
        .locked(locked8), .err(err8), .err_count(cnt8), .last_val(last8)
    );

    result_checker #(.LOCK_LEN(3), .ERR_W(2)) u2 (
        .clk(clk), .rst(rst), .sel(sel), .button(button), .result(result),
        .locked(locked2), .err(err2), .err_count(cnt2), .last_val(last2)
    );

    typedef struct {
        logic       sel;
        logic       btn;
        logic [2:0] res;
        logic       lck;
        logic       er;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic s, logic b, logic [2:0] r, logic l, logic e, logic [7:0] c);
        vec_t v;
        v.sel = s; v.btn = b; v.res = r; v.lck = l; v.er = e; v.cnt = c;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic step(input logic s, input logic b, input logic [2:0] r);
        sel = s; button = b; result = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // dice lock, wrap 6->1
        tbl.push_back(mk(0, 1, 3'd1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 3'd2, 0, 0, 0));
        tbl.push_back(mk(0, 1, 3'd3, 0, 0, 0));
        tbl.push_back(mk(0, 1, 3'd4, 1, 0, 0));
        tbl.push_back(mk(0, 1, 3'd5, 1, 0, 0));
        tbl.push_back(mk(0, 1, 3'd6, 1, 0, 0));
        tbl.push_back(mk(0, 1, 3'd1, 1, 0, 0));
        // hold at 4 for five cycles, then jump 4->6
        tbl.push_back(mk(0, 1, 3'd2, 1, 0, 0));
        tbl.push_back(mk(0, 1, 3'd3, 1, 0, 0));
        tbl.push_back(mk(0, 0, 3'd4, 1, 0, 0));
        tbl.push_back(mk(0, 0, 3'd4, 1, 0, 0));
        tbl.push_back(mk(0, 0, 3'd4, 1, 0, 0));
        tbl.push_back(mk(0, 0, 3'd4, 1, 0, 0));
        tbl.push_back(mk(0, 1, 3'd4, 1, 0, 0));
        tbl.push_back(mk(0, 1, 3'd6, 0, 1, 1));
        tbl.push_back(mk(0, 1, 3'd1, 0, 0, 1));
        tbl.push_back(mk(0, 1, 3'd2, 0, 0, 1));
        tbl.push_back(mk(0, 1, 3'd3, 1, 0, 1));
        // source switch while locked
        tbl.push_back(mk(1, 1, 3'd4, 0, 0, 1));
        // lights lock, illegal 111 injection, recovery via VERIFY
        tbl.push_back(mk(1, 0, 3'b100, 0, 0, 1));
        tbl.push_back(mk(1, 0, 3'b110, 0, 0, 1));
        tbl.push_back(mk(1, 0, 3'b001, 0, 0, 1));
        tbl.push_back(mk(1, 0, 3'b010, 1, 0, 1));
        tbl.push_back(mk(1, 0, 3'b100, 1, 0, 1));
        tbl.push_back(mk(1, 0, 3'b111, 0, 1, 2));
        tbl.push_back(mk(1, 0, 3'b110, 0, 0, 2));
        tbl.push_back(mk(1, 0, 3'b001, 0, 0, 2));
        tbl.push_back(mk(1, 0, 3'b010, 0, 0, 2));
        tbl.push_back(mk(1, 0, 3'b100, 1, 0, 2));
        // switch back to dice
        tbl.push_back(mk(0, 1, 3'd1, 0, 0, 2));

        #1 rst = 1'b0;
        #1;
        chk("rst_locked", 0, locked8, 0);
        chk("rst_err",    0, err8,    0);
        chk("rst_cnt",    0, cnt8,    0);
        chk("rst_last",   0, last8,   0);
        #5 rst = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].sel, tbl[i].btn, tbl[i].res);
            chk("locked",   i, locked8, tbl[i].lck);
            chk("err",      i, err8,    tbl[i].er);
            chk("err_cnt",  i, cnt8,    tbl[i].cnt);
            chk("last_val", i, last8,   tbl[i].res);
        end
        chk("cnt2_after_table", 0, cnt2, 2);

        // five lock/mismatch rounds; narrow counter must stick at 3
        for (int k = 0; k < 5; k++) begin
            step(0, 1, 3'd1);
            step(0, 1, 3'd2);
            step(0, 1, 3'd3);
            chk("sat_lock_r3", k, locked8, (k == 0) ? 0 : 1);
            step(0, 1, 3'd4);
            chk("sat_lock_r4", k, locked8, 1);
            step(0, 1, 3'd6);
            chk("sat_err",    k, err8,    1);
            chk("sat_locked", k, locked8, 0);
            chk("sat_cnt8",   k, cnt8,    3 + k);
            chk("sat_cnt2",   k, cnt2,    3);
            chk("sat_err2",   k, err2,    1);
        end
        step(0, 1, 3'd1);
        chk("err_one_cycle", 0, err8, 0);

        // async reset mid-sequence, checked before the next clock edge
        step(0, 1, 3'd2);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_locked", 0, locked8, 0);
        chk("mid_rst_err",    0, err8,    0);
        chk("mid_rst_cnt8",   0, cnt8,    0);
        chk("mid_rst_cnt2",   0, cnt2,    0);
        chk("mid_rst_last",   0, last8,   0);
        chk("mid_rst_last2",  0, last2,   0);
        @(posedge clk);
        #2 rst = 1'b1;
        step(0, 0, 3'd0);
        chk("post_rst_locked", 0, locked8, 0);
        chk("post_rst_cnt",    0, cnt8,    0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
